// File: rtl/hbmc_ebuf_seq_if.sv
// Signal bundle between the HyperBus read path, the elastic buffer and the
// fabric consumer of the read-side sequencer hbmc_ebuf_seq.
//
// Handshake semantics: start is a single-cycle request that is only taken
// while busy is low; m_valid qualifies m_data on every cycle it is high,
// there is no ready/backpressure, so a consumer must take each valid word
// in the cycle it is presented; m_last marks the final word of a burst and
// done pulses for one cycle when the burst (normal or aborted) is finished.
interface hbmc_ebuf_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  len;
  logic                  abort;
  logic                  ebuf_arst;
  logic [DATA_WIDTH-1:0] ebuf_dout;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  busy;
  logic                  done;
  logic                  err;

  // Requester/consumer side: drives requests and buffer data.
  modport master (
    output start, len, abort, ebuf_dout,
    input  ebuf_arst, m_data, m_valid, m_last, busy, done, err
  );

  // Sequencer side.
  modport slave (
    input  start, len, abort, ebuf_dout,
    output ebuf_arst, m_data, m_valid, m_last, busy, done, err
  );
endinterface

// File: rtl/hbmc_ebuf_seq.sv
// Read-side sequencer for the HyperBus elastic buffer. For every read burst
// it resets the buffer, waits for the buffer pointers to settle, then
// streams exactly len words into the fabric domain and pulses done.
// Optional marker alignment is built when HBMC_EBUF_SEQ_ALIGN_EN is defined:
// words are then discarded until MARKER is seen (bounded by ALIGN_TIMEOUT).
module hbmc_ebuf_seq #(
  parameter int DATA_WIDTH    = 16,
  parameter int LEN_WIDTH     = 8,
  parameter int FLUSH_CYCLES  = 4,
`ifdef HBMC_EBUF_SEQ_ALIGN_EN
  parameter logic [DATA_WIDTH-1:0] MARKER = 16'hA55A,
  parameter int ALIGN_TIMEOUT = 16,
`endif
  parameter int SETTLE_CYCLES = 6
) (
  input  logic            clk,
  input  logic            rst,
  hbmc_ebuf_seq_if.slave  bus,
  output logic [2:0]      state_dbg
);

  localparam int CNT_MAX = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FLUSH  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef HBMC_EBUF_SEQ_ALIGN_EN
  localparam logic [2:0] S_ALIGN  = 3'd5;
  localparam int ACNT_W = $clog2(ALIGN_TIMEOUT + 1);
  localparam logic [ACNT_W-1:0] ALIGN_LAST = ACNT_W'(ALIGN_TIMEOUT - 1);
`endif

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  ebuf_arst_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic                  m_last_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  abort_now;
`ifdef HBMC_EBUF_SEQ_ALIGN_EN
  logic [ACNT_W-1:0]     acnt;
`endif

  assign bus.ebuf_arst = ebuf_arst_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_last    = m_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign state_dbg     = state;

  // Abort only has an effect while a burst is actively in flight.
  always_comb begin
    abort_now = 1'b0;
    if (bus.abort) begin
      abort_now = (state == S_FLUSH) || (state == S_SETTLE) || (state == S_STREAM);
`ifdef HBMC_EBUF_SEQ_ALIGN_EN
      if (state == S_ALIGN) abort_now = 1'b1;
`endif
    end
  end

  // Burst sequencing: flush, settle, optional align, stream, complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      remaining   <= '0;
      ebuf_arst_q <= 1'b1;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef HBMC_EBUF_SEQ_ALIGN_EN
      acnt        <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort_now) begin
        // Abort wins over every in-flight step; the buffer is put back in reset.
        m_valid_q   <= 1'b0;
        m_last_q    <= 1'b0;
        ebuf_arst_q <= 1'b1;
        done_q      <= 1'b1;
        err_q       <= 1'b1;
        state       <= S_DONE;
      end else begin
        case (state)
          S_IDLE: begin
            ebuf_arst_q <= 1'b1;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            if (bus.start) begin
              remaining <= bus.len;
              err_q     <= 1'b0;
              busy_q    <= 1'b1;
              cnt       <= '0;
              state     <= S_FLUSH;
            end
          end
          S_FLUSH: begin
            if (cnt == FLUSH_LAST) begin
              cnt         <= '0;
              ebuf_arst_q <= 1'b0;
              state       <= S_SETTLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt <= '0;
              if (remaining == '0) begin
                done_q <= 1'b1;
                state  <= S_DONE;
              end else begin
`ifdef HBMC_EBUF_SEQ_ALIGN_EN
                acnt  <= '0;
                state <= S_ALIGN;
`else
                state <= S_STREAM;
`endif
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef HBMC_EBUF_SEQ_ALIGN_EN
          S_ALIGN: begin
            // The marker itself is swallowed; the word after it is the first output.
            if (bus.ebuf_dout == MARKER) begin
              state <= S_STREAM;
            end else if (acnt == ALIGN_LAST) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              acnt <= acnt + 1'b1;
            end
          end
`endif
          S_STREAM: begin
            if (remaining != '0) begin
              m_data_q  <= bus.ebuf_dout;
              m_valid_q <= 1'b1;
              m_last_q  <= (remaining == LEN_WIDTH'(1));
              remaining <= remaining - 1'b1;
            end else begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              done_q    <= 1'b1;
              state     <= S_DONE;
            end
          end
          S_DONE: begin
            busy_q      <= 1'b0;
            ebuf_arst_q <= 1'b1;
            state       <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
      // A request while a burst is in flight is dropped but remembered.
      if (busy_q && bus.start) err_q <= 1'b1;
    end
  end

endmodule

// File: doc/hbmc_ebuf_seq.md
Name: hbmc_ebuf_seq

Overview:
- Read-side sequencer for the elastic buffer that carries captured HyperBus read data into the fabric clock domain.
- Per read burst: resets the buffer, waits for its pointers to settle, streams exactly LEN words to the fabric with valid qualification, then reports completion.
- Sits in the clk domain between the HyperBus transaction FSM (issues start/len) and the elastic buffer (provides data, receives reset).

Parameters:
- DATA_WIDTH, 16, width of elastic buffer data word and output data.
- LEN_WIDTH, 8, width of burst length field; max burst is 2^LEN_WIDTH - 1 words.
- FLUSH_CYCLES, 4, cycles ebuf_arst is held high per burst (must be at least 1).
- SETTLE_CYCLES, 6, cycles waited after ebuf_arst release before the first data word is taken; covers the 3-stage reset synchronisers plus the 2-entry pointer margin.

Ports:
- clk  in  1  fabric clock; also the buffer's read-side clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle burst request; accepted only when busy=0.
- len  in  LEN_WIDTH  burst word count, sampled with start; 0 is legal.
- abort  in  1  terminate current burst.
- ebuf_arst  out  1  reset to elastic buffer, registered.
- ebuf_dout  in  DATA_WIDTH  elastic buffer read data.
- m_data  out  DATA_WIDTH  output word, registered.
- m_valid  out  1  m_data qualifier; no backpressure.
- m_last  out  1  high with the final word of a burst.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag, cleared by the next accepted start.

Behaviour:
- Reset values: ebuf_arst=1, m_data=0, m_valid=0, m_last=0, busy=0, done=0, err=0. State is IDLE.
- States: IDLE, FLUSH, SETTLE, STREAM, DONE (ALIGN is added with the optional feature).
- IDLE:
  - ebuf_arst=1 is held idle so the buffer stays quiescent.
  - start=1: latch len into remaining counter, clear err, busy=1, go to FLUSH.
  - start while busy=1: ignored and sets err.
- FLUSH: ebuf_arst=1 for FLUSH_CYCLES cycles, then ebuf_arst=0 and go to SETTLE.
- SETTLE:
  - Wait SETTLE_CYCLES cycles.
  - Then go to STREAM if remaining!=0; else go to DONE with m_valid never asserted.
- STREAM:
  - Each cycle: m_data<=ebuf_dout, m_valid<=1, remaining decrements.
  - m_last<=1 when remaining==1.
  - The cycle after the last word: m_valid=0, go to DONE.
  - Exactly len consecutive valid cycles; no gaps.
- DONE:
  - done=1 for one cycle, busy<=0, ebuf_arst<=1, go to IDLE.
  - First m_valid appears FLUSH_CYCLES+SETTLE_CYCLES+2 cycles after the start cycle.
- Counters:
  - Flush/settle share one counter sized clog2(max(FLUSH_CYCLES,SETTLE_CYCLES)+1).
  - remaining is LEN_WIDTH bits; no wrap, decrement stops at 0.
- abort:
  - In FLUSH/SETTLE/STREAM/ALIGN: next cycle m_valid=0, m_last=0, ebuf_arst=1, go to DONE (done pulses, err=1).
  - abort in IDLE or DONE is ignored.
  - abort and start in the same IDLE cycle: start wins.
- rst mid-burst: all outputs return to reset values on the next edge; no done pulse.

Optional Feature:
- Macro: HBMC_EBUF_SEQ_ALIGN_EN.
- When defined:
  - Parameters MARKER (DATA_WIDTH, default 16'hA55A) and ALIGN_TIMEOUT (default 16) are added.
  - SETTLE exits to ALIGN instead of STREAM.
  - ALIGN discards words until ebuf_dout==MARKER; the marker itself is not output, and STREAM starts the next cycle.
  - No match within ALIGN_TIMEOUT cycles: err=1, go to DONE with zero words output.
  - len==0 skips ALIGN.
- When undefined: no ALIGN state, no extra parameters, and SETTLE goes directly to STREAM.

Test Plan:
- Reset, then start with len=4 and ebuf_dout incrementing from 0x0010 -> ebuf_arst high cycles 1-4, m_valid high exactly 4 consecutive cycles starting 12 cycles after start, m_last on 4th word, done one cycle later, err=0.
- start with len=0 -> ebuf_arst pulse, no m_valid, done 11 cycles after start, busy low after done.
- Back-to-back: start len=2, second start asserted during STREAM -> second ignored, err=1 at done; a third start after done clears err and runs normally.
- abort asserted on 2nd STREAM word of len=8 -> m_valid low next cycle, done pulse, err=1, ebuf_arst=1.
- rst asserted during SETTLE -> next edge all outputs at reset values, no done; a subsequent start with len=3 behaves nominally.
- HBMC_EBUF_SEQ_ALIGN_EN defined:
  - MARKER presented 3 cycles into ALIGN, len=2 -> next two words output, m_last on 2nd.
  - MARKER absent -> err=1 and done after 16 ALIGN cycles, no m_valid.
